lvt_write_scheduler: RTL

//  Front-end scheduler for the register-based LVT multiported memory. Accepts one

---
 rtl/lvt_write_scheduler.sv | 109 ++++++++++
 1 files changed

// File: rtl/lvt_write_scheduler.sv
// lvt_write_scheduler: rotating-priority write scheduler with post-reset init sweep for an LVT memory.
// Optional conflict counter output enabled by defining LVT_SCHED_CONFLICT_CNT_EN.
module lvt_write_scheduler #(
  parameter int P = 4,
  parameter int N_PE_BITS = 2,
  parameter int INDEX_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [P-1:0]               req_valid,
  input  logic [P*INDEX_WIDTH-1:0]   req_addr,
  input  logic [P*DATA_WIDTH-1:0]    req_data,
  output logic [P-1:0]               req_ready,
  output logic [P-1:0]               w_en,
  output logic [P*INDEX_WIDTH-1:0]   write_addr,
  output logic [P*DATA_WIDTH-1:0]    write_data,
  output logic                       init_busy,
  output logic [N_PE_BITS-1:0]       prio_ptr
`ifdef LVT_SCHED_CONFLICT_CNT_EN
  ,output logic [15:0]               conflict_cnt
`endif
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [N_PE_BITS-1:0]   prio_q, prio_d;
  logic [P-1:0]           w_en_q, w_en_d, grant;
  logic [P*INDEX_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [P*DATA_WIDTH-1:0]  write_data_q, write_data_d;
  logic                   run, conflict;
  // Distance of a port from the priority pointer; smaller distance wins.
  function automatic logic [N_PE_BITS-1:0] rank(input int x, input logic [N_PE_BITS-1:0] p);
    return N_PE_BITS'(x) - p;
  endfunction
  assign run = state_q == RUN;
  always_comb begin
    grant = '0;
    conflict = 1'b0;
    for (int i = 0; i < P; i++) begin
      grant[i] = run && req_valid[i];
      for (int j = 0; j < P; j++) begin
        if (j != i && req_valid[i] && req_valid[j] &&
            req_addr[j*INDEX_WIDTH +: INDEX_WIDTH] == req_addr[i*INDEX_WIDTH +: INDEX_WIDTH]) begin
          conflict = run;
          if (rank(j, prio_q) < rank(i, prio_q)) grant[i] = 1'b0;
        end
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    prio_d = prio_q;
    w_en_d = '0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (!run) begin
      w_en_d = P'(1);
      write_addr_d = '0;
      write_addr_d[0 +: INDEX_WIDTH] = sweep_q;
      write_data_d = '0;
      sweep_d = sweep_q + 1'b1;
      state_d = &sweep_q ? RUN : INIT;
    end else begin
      w_en_d = grant;
      for (int i = 0; i < P; i++) begin
        if (grant[i]) begin
          write_addr_d[i*INDEX_WIDTH +: INDEX_WIDTH] = req_addr[i*INDEX_WIDTH +: INDEX_WIDTH];
          write_data_d[i*DATA_WIDTH +: DATA_WIDTH] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      prio_d = conflict ? prio_q + 1'b1 : prio_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      prio_q <= '0;
      w_en_q <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      prio_q <= prio_d;
      w_en_q <= w_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end
`ifdef LVT_SCHED_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (conflict && !(&cnt_q)) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign conflict_cnt = cnt_q;
`endif
  assign req_ready = grant;
  assign w_en = w_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign init_busy = !run;
  assign prio_ptr = prio_q;
endmodule
